// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// State and owner encodings plus the starvation counter width.
package mem_arb_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    function automatic state_e busy_of(input owner_e o);
        return (o == OWN_I) ? BUSY_I : BUSY_D;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory-side bundle of the arbiter.
// slave is the arbiter's view, master the environment's view.
interface mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wen;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wen;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_addr, d_wdata, d_wen,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_addr, m_wdata, m_wen,
        input  m_ready, m_rvalid, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_addr, d_wdata, d_wen,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_addr, m_wdata, m_wen,
        output m_ready, m_rvalid, m_rdata
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of cycles a fetch request has waited ungranted.
// hit flags that the wait has reached LIMIT.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req,
    input  logic                    i_gnt,
    output logic [STARVE_CNT_W-1:0] cnt,
    output logic                    hit
);

    localparam logic [STARVE_CNT_W-1:0] CMAX = '1;
    localparam logic [STARVE_CNT_W-1:0] LIM  = STARVE_CNT_W'(LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!i_req || i_gnt) begin
            cnt <= '0;
        end else if (cnt != CMAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt >= LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-outstanding memory arbiter: data wins by default,
// fetch wins once it has waited STARVE_LIMIT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus,
    output logic          err_stray
);

    state_e                  state;
    state_e                  state_n;
    owner_e                  win;
    logic                    issue_ok;
    logic                    acc;
    logic                    rsp_done;
    logic                    starve_hit;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (bus.i_req),
        .i_gnt (bus.i_gnt),
        .cnt   (starve_cnt),
        .hit   (starve_hit)
    );

    // A new request may go out in the same cycle the previous one returns.
    always_comb begin
        issue_ok = rst_n && (state == IDLE || bus.m_rvalid);
        rsp_done = rst_n && (state != IDLE) && bus.m_rvalid;
        win = OWN_D;
        if (bus.i_req && (starve_hit || !bus.d_req)) begin
            win = OWN_I;
        end
        bus.m_req   = issue_ok && (bus.i_req || bus.d_req);
        bus.m_addr  = (win == OWN_I) ? bus.i_addr : bus.d_addr;
        bus.m_wen   = (win == OWN_I) ? 4'b0000 : bus.d_wen;
        bus.m_wdata = bus.d_wdata;
        acc         = bus.m_req && bus.m_ready;
        bus.i_gnt   = acc && (win == OWN_I);
        bus.d_gnt   = acc && (win == OWN_D);
        bus.i_rvalid = rsp_done && (state == BUSY_I);
        bus.d_rvalid = rsp_done && (state == BUSY_D);
        bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
    end

    always_comb begin
        state_n = state;
        unique case (1'b1)
            acc:              state_n = busy_of(win);
            !acc && rsp_done: state_n = IDLE;
            default:          state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Responses arriving with nothing outstanding are dropped but remembered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_stray <= 1'b0;
        end else if (state == IDLE && bus.m_rvalid) begin
            err_stray <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference
// model and a simple fixed-latency memory responder.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic err_stray;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_stray (err_stray)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    logic        pend = 1'b0;
    int          due  = 0;
    logic [31:0] pdata;

    // model: owner 0 = none, 1 = fetch, 2 = data
    int own    = 0;
    int scnt   = 0;
    bit merr   = 1'b0;
    bit mstore = 1'b0;

    logic        s_ig, s_dg, s_irv, s_drv, s_mreq, s_err;
    logic [31:0] s_ird, s_drd, s_maddr, s_mwd;
    logic [3:0]  s_mwen, s_cnt;

    int gk;
    int n_acc;
    int n_i;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit issue, emreq, wi, acc, eirv, edrv;
        issue = rst_n && (own == 0 || bus.m_rvalid);
        emreq = issue && (bus.i_req || bus.d_req);
        wi    = bus.i_req && (scnt >= LIMIT || !bus.d_req);
        acc   = emreq && bus.m_ready;
        eirv  = rst_n && own == 1 && bus.m_rvalid;
        edrv  = rst_n && own == 2 && bus.m_rvalid;
        chk1("m_req", bus.m_req, emreq);
        chk1("i_gnt", bus.i_gnt, acc && wi);
        chk1("d_gnt", bus.d_gnt, acc && !wi);
        chk1("i_rvalid", bus.i_rvalid, eirv);
        chk1("d_rvalid", bus.d_rvalid, edrv);
        if (eirv) chk("i_rdata", bus.i_rdata, bus.m_rdata);
        if (edrv && !mstore) chk("d_rdata", bus.d_rdata, bus.m_rdata);
        if (!rst_n) begin
            chk("i_rdata_rst", bus.i_rdata, 32'h0);
            chk("d_rdata_rst", bus.d_rdata, 32'h0);
        end
        if (emreq) begin
            chk("m_addr", bus.m_addr, wi ? bus.i_addr : bus.d_addr);
            chk("m_wen", 32'(bus.m_wen), wi ? 32'h0 : 32'(bus.d_wen));
            if (!wi) chk("m_wdata", bus.m_wdata, bus.d_wdata);
        end
        chk1("err_stray", err_stray, merr);
        chk("starve_cnt", 32'(u_dut.starve_cnt), scnt);
        chk1("rv_excl", bus.i_rvalid && bus.d_rvalid, 1'b0);
        chk1("gnt_ready", (bus.i_gnt || bus.d_gnt) && !bus.m_ready, 1'b0);
        if (!rst_n) begin
            own  = 0;
            scnt = 0;
            merr = 1'b0;
        end else begin
            if (own == 0 && bus.m_rvalid) merr = 1'b1;
            if (acc) begin
                own    = wi ? 1 : 2;
                mstore = !wi && bus.d_wen != 4'b0000;
            end else if (bus.m_rvalid) begin
                own = 0;
            end
            if (!bus.i_req || (acc && wi)) scnt = 0;
            else if (scnt < 15) scnt = scnt + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        s_ig    = bus.i_gnt;
        s_dg    = bus.d_gnt;
        s_irv   = bus.i_rvalid;
        s_drv   = bus.d_rvalid;
        s_ird   = bus.i_rdata;
        s_drd   = bus.d_rdata;
        s_mreq  = bus.m_req;
        s_maddr = bus.m_addr;
        s_mwen  = bus.m_wen;
        s_mwd   = bus.m_wdata;
        s_err   = err_stray;
        s_cnt   = u_dut.starve_cnt;
        if (bus.m_req && bus.m_ready) begin
            pend  = 1'b1;
            due   = cyc + lat;
            pdata = mem_fn(bus.m_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend && due == cyc) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = pdata;
            pend         = 1'b0;
        end else begin
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.i_req    = 1'b0;
        bus.i_addr   = 32'h0;
        bus.d_req    = 1'b1;
        bus.d_addr   = 32'h100;
        bus.d_wdata  = 32'h0;
        bus.d_wen    = 4'b0000;
        bus.m_ready  = 1'b1;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;

        // reset holds everything quiet even with a request pending
        tick();
        tick();
        chk1("rst_m_req", s_mreq, 1'b0);
        chk1("rst_d_gnt", s_dg, 1'b0);
        chk1("rst_err", s_err, 1'b0);
        chk("rst_d_rdata", s_drd, 32'h0);
        rst_n     = 1'b1;
        bus.d_req = 1'b0;
        tick();

        // lone fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        tick();
        chk1("fetch_gnt", s_ig, 1'b1);
        chk("fetch_addr", s_maddr, 32'h10);
        bus.i_req = 1'b0;
        tick();
        chk1("fetch_rv", s_irv, 1'b1);
        chk("fetch_data", s_ird, 32'h0050_0093);
        tick();
        chk1("fetch_idle", s_irv, 1'b0);

        // collision: data store wins, fetch goes on the response cycle
        lat         = 2;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h40;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'hCAFE_F00D;
        bus.d_wen   = 4'b1111;
        tick();
        chk1("col_dgnt", s_dg, 1'b1);
        chk1("col_ignt", s_ig, 1'b0);
        chk("col_wen", 32'(s_mwen), 32'hF);
        chk("col_wdata", s_mwd, 32'hCAFE_F00D);
        bus.d_req = 1'b0;
        tick();
        chk1("col_wait", s_ig, 1'b0);
        tick();
        chk1("col_drv", s_drv, 1'b1);
        chk1("col_ignt2", s_ig, 1'b1);
        bus.i_req = 1'b0;
        tick();
        tick();
        chk1("col_irv", s_irv, 1'b1);
        chk("col_idata", s_ird, 32'h0040_FFBF);
        tick();

        // starvation
        lat        = 1;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h300;
        bus.d_wen  = 4'b0000;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h44;
        gk = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (s_ig) begin
                gk = k;
                break;
            end
        end
        chk("starve_k", gk, 4);
        tick();
        chk("starve_clr", 32'(s_cnt), 32'h0);
        chk1("starve_irv", s_irv, 1'b1);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        chk1("starve_drv", s_drv, 1'b1);
        tick();

        // back-pressure
        bus.m_ready = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h400;
        bus.d_wdata = 32'h1234_5678;
        bus.d_wen   = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("bp_nognt", s_dg, 1'b0);
            chk("bp_addr", s_maddr, 32'h400);
        end
        bus.m_ready = 1'b1;
        tick();
        chk1("bp_gnt", s_dg, 1'b1);
        bus.d_req = 1'b0;
        tick();
        chk1("bp_drv", s_drv, 1'b1);
        tick();

        // back-to-back with both requesters busy
        bus.d_wen  = 4'b0000;
        bus.d_addr = 32'h800;
        bus.i_addr = 32'h80;
        bus.d_req  = 1'b1;
        bus.i_req  = 1'b1;
        n_acc = 0;
        n_i   = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (s_ig || s_dg) n_acc++;
            if (s_ig) n_i++;
        end
        chk("b2b_acc", n_acc, 12);
        chk("b2b_ignt", n_i, 2);
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        tick();
        tick();

        // reset while a load is outstanding
        lat        = 3;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h500;
        tick();
        chk1("rmo_gnt", s_dg, 1'b1);
        bus.d_req = 1'b0;
        rst_n     = 1'b0;
        tick();
        chk1("rmo_rst_drv", s_drv, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        chk1("rmo_stray_drv", s_drv, 1'b0);
        tick();
        chk1("rmo_err", s_err, 1'b1);
        lat        = 1;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h600;
        tick();
        chk1("rmo_gnt2", s_dg, 1'b1);
        bus.d_req = 1'b0;
        tick();
        chk1("rmo_drv2", s_drv, 1'b1);
        chk("rmo_data2", s_drd, 32'h0600_F9FF);
        chk1("rmo_err_hold", s_err, 1'b1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
